// File: rtl/gray_ptr_sync_fifo.sv
// Single-clock FIFO with Gray-coded read/write pointers; full/empty come from
// comparing the registered Gray pointers, the scheme later reused across clocks.
module gray_ptr_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_full,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic [AW:0]   o_wptr_G,
    output logic [AW:0]   o_rptr_G,
    output logic          o_ovf,
    output logic          o_udf
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [AW:0]   wb_r, rb_r;
    logic [AW:0]   wg_r, rg_r;
    logic [DW-1:0] rd_data_r;
    logic          ovf_r, udf_r;
    logic [DW-1:0] mem_r [0:DEPTH-1];

    logic [AW:0]   wb_nxt_s, rb_nxt_s;
    logic          full_s, empty_s, wr_ok_s, rd_ok_s;

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign empty_s  = (wg_r == rg_r);
    assign full_s   = (wg_r == {~rg_r[AW:AW-1], rg_r[AW-2:0]});
    assign wr_ok_s  = i_wr_en && !full_s;
    assign rd_ok_s  = i_rd_en && !empty_s;
    assign wb_nxt_s = wb_r + PTR_ONE;
    assign rb_nxt_s = rb_r + PTR_ONE;

    // Pointer, Gray pointer, read data and sticky error registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wb_r      <= {(AW+1){1'b0}};
            rb_r      <= {(AW+1){1'b0}};
            wg_r      <= {(AW+1){1'b0}};
            rg_r      <= {(AW+1){1'b0}};
            rd_data_r <= {DW{1'b0}};
            ovf_r     <= 1'b0;
            udf_r     <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wb_r <= wb_nxt_s;
                wg_r <= bin2gray(wb_nxt_s);
            end
            if (rd_ok_s) begin
                rb_r      <= rb_nxt_s;
                rg_r      <= bin2gray(rb_nxt_s);
                rd_data_r <= mem_r[rb_r[AW-1:0]];
            end
            if (i_wr_en && full_s) begin
                ovf_r <= 1'b1;
            end
            if (i_rd_en && empty_s) begin
                udf_r <= 1'b1;
            end
        end
    end

    // Storage array; contents are not reset, stale words are unreachable after reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_ok_s) begin
            mem_r[wb_r[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_full    = full_s;
    assign o_empty   = empty_s;
    assign o_count   = wb_r - rb_r;
    assign o_wptr_G  = wg_r;
    assign o_rptr_G  = rg_r;
    assign o_rd_data = rd_data_r;
    assign o_ovf     = ovf_r;
    assign o_udf     = udf_r;

endmodule
